// File: rtl/blind_spot_monitor_n.sv
// Multi-zone blind-spot monitor: per-channel debounce/hold-off FSM plus a shared
// flash generator that escalates occupied zones to a flashing alert on turn request.
module blind_spot_monitor_n #(
    parameter int CH         = 2,
    parameter int DEB        = 3,
    parameter int HOLD       = 8,
    parameter int FLASH_HALF = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [CH-1:0]             sensor,
    input  logic [CH-1:0]             turn,
    output logic [CH-1:0]             warn,
    output logic [CH-1:0]             alert,
    output logic [$clog2(CH+1)-1:0]   active_cnt
);

    localparam int AW = $clog2(CH+1);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUAL,
        S_ACTIVE,
        S_HOLD
    } state_t;

    logic [CH-1:0] w_warn;
    logic [CH-1:0] r_turn_q;
    logic          r_phase;
    logic [FW-1:0] r_flash_cnt;
    logic          w_any;
    logic [AW-1:0] w_active;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        r_state, w_state_nx;
        logic [DW-1:0] r_deb, w_deb_nx;
        logic [HW-1:0] r_hold, w_hold_nx;
        logic          r_warn;

        always_comb begin
            w_state_nx = r_state;
            w_deb_nx   = r_deb;
            w_hold_nx  = r_hold;
            case (r_state)
                S_IDLE: begin
                    if (sensor[g]) begin
                        if (DEB == 1) begin
                            w_state_nx = S_ACTIVE;
                        end else begin
                            w_state_nx = S_QUAL;
                            w_deb_nx   = DW'(1);
                        end
                    end
                end
                S_QUAL: begin
                    if (!sensor[g]) begin
                        w_state_nx = S_IDLE;
                        w_deb_nx   = '0;
                    end else if (r_deb == DEB_LAST) begin
                        w_state_nx = S_ACTIVE;
                        w_deb_nx   = '0;
                    end else begin
                        w_deb_nx = r_deb + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (!sensor[g]) begin
                        w_state_nx = S_HOLD;
                        w_hold_nx  = HOLD_LAST;
                    end
                end
                S_HOLD: begin
                    // A returning target resumes the warning without re-debouncing.
                    if (sensor[g]) begin
                        w_state_nx = S_ACTIVE;
                        w_hold_nx  = '0;
                    end else if (r_hold == '0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_hold_nx = r_hold - 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_deb_nx   = '0;
                    w_hold_nx  = '0;
                end
            endcase
            if (!en) begin
                w_state_nx = S_IDLE;
                w_deb_nx   = '0;
                w_hold_nx  = '0;
            end
        end

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                r_state <= S_IDLE;
                r_deb   <= '0;
                r_hold  <= '0;
                r_warn  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_deb   <= w_deb_nx;
                r_hold  <= w_hold_nx;
                r_warn  <= (w_state_nx == S_ACTIVE) || (w_state_nx == S_HOLD);
            end
        end

        assign w_warn[g] = r_warn;
    end

    assign w_any = |(w_warn & r_turn_q);

    // Phase parks at 1 while idle so a new alert lights on its very first cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_turn_q    <= '0;
            r_phase     <= 1'b1;
            r_flash_cnt <= '0;
        end else if (!en) begin
            r_turn_q    <= '0;
            r_phase     <= 1'b1;
            r_flash_cnt <= '0;
        end else begin
            r_turn_q <= turn;
            if (!w_any) begin
                r_phase     <= 1'b1;
                r_flash_cnt <= '0;
            end else if (r_flash_cnt == FLASH_LAST) begin
                r_phase     <= ~r_phase;
                r_flash_cnt <= '0;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_active = '0;
        for (int i = 0; i < CH; i++) begin
            w_active = w_active + AW'(w_warn[i]);
        end
    end

    assign warn       = w_warn;
    assign alert      = w_warn & r_turn_q & {CH{r_phase}};
    assign active_cnt = w_active;

endmodule

// File: tb/tb_blind_spot_monitor_n.sv
// Scoreboard bench for blind_spot_monitor_n at default parameters: the driver queues
// hand-computed expectations per cycle, a monitor compares after each edge or reset drop.
module tb_blind_spot_monitor_n;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en;
    logic [1:0] sensor;
    logic [1:0] turn;
    logic [1:0] warn;
    logic [1:0] alert;
    logic [1:0] active_cnt;

    typedef struct {
        logic [1:0] w;
        logic [1:0] a;
        logic [1:0] c;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    blind_spot_monitor_n #(
        .CH(2), .DEB(3), .HOLD(8), .FLASH_HALF(4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .sensor     (sensor),
        .turn       (turn),
        .warn       (warn),
        .alert      (alert),
        .active_cnt (active_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic push_exp(input logic [1:0] ew, input logic [1:0] ea, input string nm);
        exp_t x;
        x.w  = ew;
        x.a  = ea;
        x.c  = 2'(ew[0]) + 2'(ew[1]);
        x.nm = nm;
        q.push_back(x);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic step(input logic [1:0] s, input logic [1:0] t, input logic e,
                        input logic [1:0] ew, input logic [1:0] ea, input string nm);
        @(negedge CLK);
        sensor = s;
        turn   = t;
        en     = e;
        push_exp(ew, ea, nm);
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            #1;
            if (q.size() > 0) begin
                m_e = q.pop_front();
                n_tests++;
                if (warn !== m_e.w || alert !== m_e.a || active_cnt !== m_e.c) begin
                    n_fail++;
                    $display("FAIL %s: got warn=%b alert=%b active_cnt=%0d, expected warn=%b alert=%b active_cnt=%0d",
                             m_e.nm, warn, alert, active_cnt, m_e.w, m_e.a, m_e.c);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin
        RST    = 1'b0;
        en     = 1'b1;
        sensor = 2'b00;
        turn   = 2'b00;

        // Reset state, even with inputs active
        step(2'b11, 2'b11, 1'b1, 2'b00, 2'b00, "reset_state");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "reset_state");
        @(negedge CLK);
        RST = 1'b1;

        // Debounce: two highs are not enough, three are
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "deb_short");
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "deb_short");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "deb_short");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "deb_short");
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "deb_q1");
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "deb_q2");
        step(2'b01, 2'b00, 1'b1, 2'b01, 2'b00, "deb_rise");

        // Hold-off: 8 edges of warning after the sensor clears
        for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 1'b1, 2'b01, 2'b00, "hold_keep");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "hold_fall");

        // Alternating sensor never qualifies
        for (int i = 0; i < 20; i++)
            step((i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "deb_alt");

        // Re-raise during hold, then a fresh full hold
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "requal");
        step(2'b01, 2'b00, 1'b1, 2'b00, 2'b00, "requal");
        step(2'b01, 2'b00, 1'b1, 2'b01, 2'b00, "requal_rise");
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1, 2'b01, 2'b00, "hold_part");
        for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b1, 2'b01, 2'b00, "hold_reraise");
        for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 1'b1, 2'b01, 2'b00, "hold_fresh");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "hold_fresh_fall");

        // Escalation on channel 1
        step(2'b10, 2'b00, 1'b1, 2'b00, 2'b00, "esc_qual");
        step(2'b10, 2'b00, 1'b1, 2'b00, 2'b00, "esc_qual");
        step(2'b10, 2'b00, 1'b1, 2'b10, 2'b00, "esc_warn");
        for (int i = 0; i < 12; i++)
            step(2'b10, 2'b10, 1'b1, 2'b10, (i < 4 || i >= 8) ? 2'b10 : 2'b00, "esc_flash");
        step(2'b10, 2'b00, 1'b1, 2'b10, 2'b00, "esc_drop");
        step(2'b10, 2'b00, 1'b1, 2'b10, 2'b00, "esc_idle");
        step(2'b10, 2'b10, 1'b1, 2'b10, 2'b10, "esc_phase_restart");
        step(2'b10, 2'b00, 1'b1, 2'b10, 2'b00, "esc_drop2");
        for (int i = 0; i < 3; i++) step(2'b10, 2'b01, 1'b1, 2'b10, 2'b00, "esc_turn_no_warn");
        for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 1'b1, 2'b10, 2'b00, "esc_hold");
        step(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, "esc_clear");

        // Multi-channel qualify and unison flashing
        step(2'b11, 2'b00, 1'b1, 2'b00, 2'b00, "multi_qual");
        step(2'b11, 2'b00, 1'b1, 2'b00, 2'b00, "multi_qual");
        step(2'b11, 2'b00, 1'b1, 2'b11, 2'b00, "multi_rise");
        for (int i = 0; i < 9; i++)
            step(2'b11, 2'b11, 1'b1, 2'b11, (i < 4 || i >= 8) ? 2'b11 : 2'b00, "multi_flash");

        // Enable drop while alerting, then re-enable
        step(2'b11, 2'b11, 1'b0, 2'b00, 2'b00, "en_off");
        step(2'b11, 2'b11, 1'b1, 2'b00, 2'b00, "en_requal");
        step(2'b11, 2'b11, 1'b1, 2'b00, 2'b00, "en_requal");
        step(2'b11, 2'b11, 1'b1, 2'b11, 2'b11, "en_rise");
        step(2'b11, 2'b00, 1'b1, 2'b11, 2'b00, "en_turn_off");

        // Asynchronous reset mid-hold
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 2'b11, 2'b00, "pre_async_hold");
        @(negedge CLK);
        #2;
        push_exp(2'b00, 2'b00, "async_rst");
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        step(2'b11, 2'b00, 1'b1, 2'b00, 2'b00, "post_rst_q1");
        step(2'b11, 2'b00, 1'b1, 2'b00, 2'b00, "post_rst_q2");
        step(2'b11, 2'b00, 1'b1, 2'b11, 2'b00, "post_rst_rise");

        repeat (3) @(negedge CLK);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
